// File: rtl/timebase_timer.sv
// Game timebase: prescaled tick, wrapping elapsed-tick counter and
// NUM_CH independent one-shot / auto-reload countdown channels.
module timebase_timer #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int CNT_W   = 20,
  parameter int WRAP_AT = 1_000_000,
  parameter int NUM_CH  = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sync_clear,
  input  logic                    cmd_valid,
  input  logic [CH_W-1:0]         cmd_ch,
  input  logic [1:0]              cmd_op,
  input  logic                    cmd_auto,
  input  logic [CNT_W-1:0]        cmd_data,
  output logic                    tick,
  output logic [CNT_W-1:0]        elapsed,
  output logic                    wrap,
  output logic [NUM_CH*CNT_W-1:0] ch_count,
  output logic [NUM_CH-1:0]       ch_running,
  output logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH-1:0]       ch_expired
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PS_W     = $clog2(PRESCALE);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] WRAP_V  = CNT_W'(WRAP_AT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } ch_st_e;

  logic [PS_W-1:0]  ps_q, ps_d;
  logic [CNT_W-1:0] el_q, el_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             tick_now;

  logic [CNT_W-1:0] rld_q [NUM_CH];
  logic [CNT_W-1:0] rld_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  ch_st_e           st_q  [NUM_CH];
  ch_st_e           st_d  [NUM_CH];
  logic [NUM_CH-1:0] auto_q, auto_d;
  logic [NUM_CH-1:0] exp_q, exp_d;
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] done_q, done_d;

  // sync_clear suppresses the tick and wins over enable
  always_comb begin
    ps_d     = ps_q;
    el_d     = el_q;
    wrap_d   = 1'b0;
    tick_now = enable && !sync_clear && (ps_q == PS_LAST);
    if (sync_clear) begin
      ps_d = '0;
      el_d = '0;
    end else if (enable) begin
      ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
    end
    if (tick_now) begin
      if (el_q == WRAP_V) begin
        el_d   = '0;
        wrap_d = 1'b1;
      end else begin
        el_d = el_q + ONE;
      end
    end
    tick_d = tick_now;
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      rld_d[i]  = rld_q[i];
      cnt_d[i]  = cnt_q[i];
      st_d[i]   = st_q[i];
      auto_d[i] = auto_q[i];
      exp_d[i]  = 1'b0;
      if (cmd_valid && (int'(cmd_ch) == i)) begin
        unique case (cmd_op)
          OP_LOAD: begin
            rld_d[i]  = cmd_data;
            cnt_d[i]  = cmd_data;
            auto_d[i] = cmd_auto;
            st_d[i]   = ST_IDLE;
          end
          OP_START: begin
            if (st_q[i] == ST_DONE) begin
              cnt_d[i] = rld_q[i];
              st_d[i]  = ST_RUN;
            end else if (st_q[i] != ST_RUN) begin
              st_d[i] = ST_RUN;
            end
          end
          OP_PAUSE: begin
            if (st_q[i] == ST_RUN) st_d[i] = ST_PAUSE;
          end
          OP_CLEAR: begin
            cnt_d[i] = '0;
            st_d[i]  = ST_IDLE;
          end
          default: ;
        endcase
      end else if (tick_now && (st_q[i] == ST_RUN)) begin
        if (cnt_q[i] > ONE) begin
          cnt_d[i] = cnt_q[i] - ONE;
        end else if (auto_q[i]) begin
          cnt_d[i] = rld_q[i];
          exp_d[i] = 1'b1;
        end else begin
          cnt_d[i] = '0;
          st_d[i]  = ST_DONE;
          exp_d[i] = 1'b1;
        end
      end
      run_d[i]  = (st_d[i] == ST_RUN);
      done_d[i] = (st_d[i] == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q   <= '0;
      el_q   <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      auto_q <= '0;
      exp_q  <= '0;
      run_q  <= '0;
      done_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rld_q[i] <= '0;
        cnt_q[i] <= '0;
        st_q[i]  <= ST_IDLE;
      end
    end else begin
      ps_q   <= ps_d;
      el_q   <= el_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      auto_q <= auto_d;
      exp_q  <= exp_d;
      run_q  <= run_d;
      done_q <= done_d;
      for (int i = 0; i < NUM_CH; i++) begin
        rld_q[i] <= rld_d[i];
        cnt_q[i] <= cnt_d[i];
        st_q[i]  <= st_d[i];
      end
    end
  end

  assign tick       = tick_q;
  assign elapsed    = el_q;
  assign wrap       = wrap_q;
  assign ch_running = run_q;
  assign ch_done    = done_q;
  assign ch_expired = exp_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign ch_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_timebase_timer.sv
// Scoreboard bench for timebase_timer: expectations are queued with the
// edge number they apply to; a negedge monitor pops and compares them.
module tb_timebase_timer;

  localparam int CNT_W  = 4;
  localparam int NUM_CH = 2;

  localparam int S_TICK = 0;
  localparam int S_EL   = 1;
  localparam int S_WRAP = 2;
  localparam int S_C0   = 3;
  localparam int S_C1   = 4;
  localparam int S_RUN  = 5;
  localparam int S_DONE = 6;
  localparam int S_EXP  = 7;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable;
  logic                    sync_clear;
  logic                    cmd_valid;
  logic [0:0]              cmd_ch;
  logic [1:0]              cmd_op;
  logic                    cmd_auto;
  logic [CNT_W-1:0]        cmd_data;
  logic                    tick;
  logic [CNT_W-1:0]        elapsed;
  logic                    wrap;
  logic [NUM_CH*CNT_W-1:0] ch_count;
  logic [NUM_CH-1:0]       ch_running;
  logic [NUM_CH-1:0]       ch_done;
  logic [NUM_CH-1:0]       ch_expired;

  timebase_timer #(
    .CLK_HZ (10),
    .TICK_HZ(1),
    .CNT_W  (CNT_W),
    .WRAP_AT(3),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sync_clear(sync_clear),
    .cmd_valid (cmd_valid),
    .cmd_ch    (cmd_ch),
    .cmd_op    (cmd_op),
    .cmd_auto  (cmd_auto),
    .cmd_data  (cmd_data),
    .tick      (tick),
    .elapsed   (elapsed),
    .wrap      (wrap),
    .ch_count  (ch_count),
    .ch_running(ch_running),
    .ch_done   (ch_done),
    .ch_expired(ch_expired)
  );

  always #5 clk = ~clk;

  // posedges since reset release
  int edges;
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  typedef struct {
    int at;
    int id;
    int val;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  string names[8] = '{"tick", "elapsed", "wrap", "ch_count0",
                      "ch_count1", "ch_running", "ch_done", "ch_expired"};

  function automatic int actual(int id);
    case (id)
      S_TICK:  return int'(tick);
      S_EL:    return int'(elapsed);
      S_WRAP:  return int'(wrap);
      S_C0:    return int'(ch_count[3:0]);
      S_C1:    return int'(ch_count[7:4]);
      S_RUN:   return int'(ch_running);
      S_DONE:  return int'(ch_done);
      default: return int'(ch_expired);
    endcase
  endfunction

  task automatic expect_at(int at, int id, int val);
    exp_t e;
    e.at  = at;
    e.id  = id;
    e.val = val;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].at == edges) begin
        n_cmp++;
        if (actual(sbq[i].id) != sbq[i].val) begin
          n_err++;
          $display("FAIL %s @edge %0d: got %0d expected %0d",
                   names[sbq[i].id], edges, actual(sbq[i].id), sbq[i].val);
        end
        sbq.delete(i);
      end else if (sbq[i].at < edges) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s @edge %0d: never sampled, expected %0d",
                 names[sbq[i].id], sbq[i].at, sbq[i].val);
        sbq.delete(i);
      end
    end
  end

  task automatic goto(int e);
    while (edges != e) @(negedge clk);
    #1;
  endtask

  task automatic do_cmd(logic ch, logic [1:0] op, logic au, int data);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_op    = op;
    cmd_auto  = au;
    cmd_data  = CNT_W'(data);
    @(negedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic expect_all_zero(int at);
    for (int id = 0; id < 8; id++) expect_at(at, id, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timed out at edge %0d", edges);
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    sync_clear = 1'b0;
    cmd_valid  = 1'b0;
    cmd_ch     = '0;
    cmd_op     = '0;
    cmd_auto   = 1'b0;
    cmd_data   = '0;
    expect_all_zero(0);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;

    // free-run
    expect_at(9, S_TICK, 0);
    expect_at(10, S_TICK, 1);
    expect_at(10, S_EL, 1);
    expect_at(11, S_TICK, 0);
    expect_at(20, S_TICK, 1);
    expect_at(20, S_EL, 2);
    expect_at(30, S_EL, 3);
    expect_at(30, S_WRAP, 0);
    expect_at(40, S_TICK, 1);
    expect_at(40, S_EL, 0);
    expect_at(40, S_WRAP, 1);
    expect_at(41, S_WRAP, 0);

    // one-shot ch0, auto-reload ch1
    goto(41);
    expect_at(42, S_C0, 3);
    expect_at(43, S_RUN, 1);
    expect_at(44, S_C1, 2);
    expect_at(45, S_RUN, 3);
    expect_at(50, S_C0, 2);
    expect_at(50, S_C1, 1);
    expect_at(60, S_C0, 1);
    expect_at(60, S_C1, 2);
    expect_at(60, S_EXP, 2);
    expect_at(60, S_RUN, 3);
    expect_at(70, S_C0, 0);
    expect_at(70, S_C1, 1);
    expect_at(70, S_EXP, 1);
    expect_at(70, S_DONE, 1);
    expect_at(70, S_RUN, 2);
    expect_at(71, S_EXP, 0);
    expect_at(80, S_C1, 2);
    expect_at(80, S_EXP, 2);
    expect_at(80, S_RUN, 2);
    do_cmd(1'b0, OP_LOAD, 1'b0, 3);
    do_cmd(1'b0, OP_START, 1'b0, 0);
    do_cmd(1'b1, OP_LOAD, 1'b1, 2);
    do_cmd(1'b1, OP_START, 1'b0, 0);

    // pause ch1 at count 2
    goto(81);
    expect_at(82, S_RUN, 0);
    expect_at(90, S_C1, 2);
    expect_at(100, S_C1, 2);
    expect_at(110, S_C1, 2);
    expect_at(110, S_EXP, 0);
    do_cmd(1'b1, OP_PAUSE, 1'b0, 0);

    // resume ch1, restart ch0 from DONE
    goto(111);
    expect_at(112, S_RUN, 2);
    expect_at(113, S_C0, 3);
    expect_at(113, S_RUN, 3);
    expect_at(113, S_DONE, 0);
    expect_at(120, S_C1, 1);
    expect_at(120, S_C0, 2);
    expect_at(120, S_EL, 0);
    do_cmd(1'b1, OP_START, 1'b0, 0);
    do_cmd(1'b0, OP_START, 1'b0, 0);

    // pause ch0 on the tick edge 140
    expect_at(130, S_C0, 1);
    expect_at(130, S_C1, 2);
    expect_at(130, S_EXP, 2);
    expect_at(140, S_TICK, 1);
    expect_at(140, S_C0, 1);
    expect_at(140, S_C1, 1);
    expect_at(140, S_RUN, 2);
    expect_at(140, S_EXP, 0);
    expect_at(150, S_C0, 1);
    expect_at(150, S_C1, 2);
    expect_at(150, S_EXP, 2);
    goto(139);
    do_cmd(1'b0, OP_PAUSE, 1'b0, 0);

    // enable low across edges 153..157
    goto(152);
    expect_at(160, S_TICK, 0);
    expect_at(160, S_EL, 3);
    expect_at(164, S_TICK, 0);
    expect_at(165, S_TICK, 1);
    expect_at(165, S_EL, 0);
    expect_at(165, S_WRAP, 1);
    expect_at(165, S_C1, 1);
    enable = 1'b0;
    goto(157);
    enable = 1'b1;

    // sync_clear at edge 178
    goto(166);
    expect_at(175, S_EL, 1);
    expect_at(175, S_C1, 2);
    expect_at(178, S_EL, 0);
    expect_at(178, S_C0, 1);
    expect_at(178, S_C1, 2);
    expect_at(178, S_RUN, 2);
    expect_at(185, S_TICK, 0);
    expect_at(187, S_TICK, 0);
    expect_at(188, S_TICK, 1);
    expect_at(188, S_EL, 1);
    expect_at(188, S_C1, 1);
    goto(177);
    sync_clear = 1'b1;
    @(negedge clk);
    #1;
    sync_clear = 1'b0;

    // async reset between edges
    goto(190);
    @(posedge clk);
    #2;
    reset = 1'b1;
    expect_all_zero(0);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
